// File: rtl/freq_gate_pkg.sv
// Shared types and constants for the gated pulse-counting display controller.
package freq_gate_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_LATCH,
    ST_HOLD
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Three-digit BCD count: hundreds, tens, units
  typedef struct packed {
    logic [BCD_W-1:0] h;
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] u;
  } bcd3_t;

  localparam bcd3_t BCD3_MAX = {4'd9, 4'd9, 4'd9};

  // Ripple BCD increment; each digit wraps 9->0 and carries into the next
  function automatic bcd3_t bcd3_inc(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.u != 4'd9) begin
      r.u = v.u + 4'd1;
    end else begin
      r.u = '0;
      if (v.t != 4'd9) begin
        r.t = v.t + 4'd1;
      end else begin
        r.t = '0;
        r.h = (v.h == 4'd9) ? '0 : v.h + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control inputs and display outputs of the gated pulse counter.
interface freq_gate_ctrl_if;
  import freq_gate_pkg::*;

  logic             i_en;
  logic             i_num_i;
  logic [SEG_W-1:0] o_tram;
  logic [SEG_W-1:0] o_chuc;
  logic [SEG_W-1:0] o_dv;
  logic             o_of;
  logic             o_valid;
  logic             o_busy;

  modport master (
    output i_en, i_num_i,
    input  o_tram, o_chuc, o_dv, o_of, o_valid, o_busy
  );

  modport slave (
    input  i_en, i_num_i,
    output o_tram, o_chuc, o_dv, o_of, o_valid, o_busy
  );

endinterface

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; codes 10-15 blank the digit.
module seg7_decoder
  import freq_gate_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Digit lookup
  always_comb begin
    seg_c = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gated pulse-counting controller: synchronise i_num_i, count rising edges
// during a fixed gate, latch the BCD result and hold it for display.
// Optional build macro BLANK_LEADING_ZERO_EN blanks leading-zero hundreds
// and tens digits (units is always shown).
module freq_gate_ctrl
  import freq_gate_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  freq_gate_ctrl_if.slave  bus
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   busy_q, valid_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_c;
  logic                   cnt_clr_c, cnt_en_c, latch_c;
  bcd3_t                  cnt_q, disp_q;
  logic                   of_int_q, of_q;
  logic [BCD_W-1:0]       code_h_c, code_t_c, code_u_c;

  // Input synchroniser and one-flop rising-edge detector
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_num_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Sequencer state, phase timer and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= latch_c;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    latch_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_en) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_clr_c = 1'b1;
        tmr_d     = '0;
        state_d   = ST_GATE;
      end
      ST_GATE: begin
        if (!bus.i_en) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en_c = 1'b1;
          if (tmr_q == GATE_LAST) state_d = ST_LATCH;
          else                    tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      ST_LATCH: begin
        latch_c = 1'b1;
        tmr_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) state_d = bus.i_en ? ST_CLEAR : ST_IDLE;
        else                    tmr_d   = tmr_q + TMR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating BCD edge counter with sticky overflow, plus display latch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      of_int_q <= 1'b0;
      disp_q   <= '0;
      of_q     <= 1'b0;
    end else begin
      if (cnt_clr_c) begin
        cnt_q    <= '0;
        of_int_q <= 1'b0;
      end else if (cnt_en_c && edge_c) begin
        if (cnt_q == BCD3_MAX) of_int_q <= 1'b1;
        else                   cnt_q    <= bcd3_inc(cnt_q);
      end
      if (latch_c) begin
        disp_q <= cnt_q;
        of_q   <= of_int_q;
      end
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  // Leading zeros map to a code the decoder renders blank
  always_comb begin
    code_h_c = (disp_q.h == '0) ? 4'hF : disp_q.h;
    code_t_c = ((disp_q.h == '0) && (disp_q.t == '0)) ? 4'hF : disp_q.t;
    code_u_c = disp_q.u;
  end
`else
  // Every digit shown as-is
  always_comb begin
    code_h_c = disp_q.h;
    code_t_c = disp_q.t;
    code_u_c = disp_q.u;
  end
`endif

  seg7_decoder u_dec_h (.bcd(code_h_c), .seg_c(bus.o_tram));
  seg7_decoder u_dec_t (.bcd(code_t_c), .seg_c(bus.o_chuc));
  seg7_decoder u_dec_u (.bcd(code_u_c), .seg_c(bus.o_dv));

  assign bus.o_of    = of_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: two instances (short gate and an
// overflow-capable long gate) checked every cycle against a measurement-phase model.
module tb_freq_gate_ctrl;

  localparam int GA = 100;
  localparam int GB = 2500;
  localparam int HC = 20;
  localparam int SS = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_gate_ctrl_if ifa ();
  freq_gate_ctrl_if ifb ();

  freq_gate_ctrl #(.GATE_CYCLES(GA), .HOLD_CYCLES(HC), .SYNC_STAGES(SS)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
  );
  freq_gate_ctrl #(.GATE_CYCLES(GB), .HOLD_CYCLES(HC), .SYNC_STAGES(SS)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
  );

  // Model: m_pos = -1 idle, 0 clear, 1..G gate cycle, G+1 latch, G+2.. hold
  int         m_pos  [2];
  int         m_cnt  [2];
  int         m_disp [2];
  logic       m_of   [2];
  logic       m_valid[2];
  logic [7:0] m_hist [2];
  bit         tog_a, tog_b;
  int         n_tests, n_fail;

  task automatic model_step(input int k);
    int g;
    logic pin, en, rise;
    g   = (k == 0) ? GA : GB;
    pin = (k == 0) ? ifa.i_num_i : ifb.i_num_i;
    en  = (k == 0) ? ifa.i_en : ifb.i_en;
    if (rst_n !== 1'b1) begin
      m_pos[k] = -1; m_cnt[k] = 0; m_disp[k] = 0;
      m_of[k] = 1'b0; m_valid[k] = 1'b0; m_hist[k] = '0;
    end else begin
      m_hist[k] = {m_hist[k][6:0], pin};
      rise = m_hist[k][SS] & ~m_hist[k][SS+1];
      if (m_pos[k] == -1) begin
        if (en) m_pos[k] = 0;
      end else if (m_pos[k] == 0) begin
        m_cnt[k] = 0;
        m_pos[k] = 1;
      end else if (m_pos[k] <= g) begin
        if (!en) m_pos[k] = -1;
        else begin
          if (rise) m_cnt[k] = m_cnt[k] + 1;
          m_pos[k] = m_pos[k] + 1;
        end
      end else if (m_pos[k] == g + 1) begin
        m_disp[k] = (m_cnt[k] > 999) ? 999 : m_cnt[k];
        m_of[k]   = (m_cnt[k] > 999);
        m_pos[k]  = m_pos[k] + 1;
      end else begin
        if (m_pos[k] == g + 1 + HC) m_pos[k] = en ? 0 : -1;
        else m_pos[k] = m_pos[k] + 1;
      end
      m_valid[k] = (m_pos[k] == g + 2);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic exp_digits(input int v, output logic [6:0] eh, output logic [6:0] et,
                            output logic [6:0] eu);
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    eh = seg_of(h); et = seg_of(t); eu = seg_of(u);
`ifdef BLANK_LEADING_ZERO_EN
    if (h == 0) eh = 7'h7F;
    if (h == 0 && t == 0) et = 7'h7F;
`endif
  endtask

  task automatic get_out(input int k, output logic [6:0] h, output logic [6:0] t,
                         output logic [6:0] u, output logic of, output logic v,
                         output logic b);
    if (k == 0) begin
      h = ifa.o_tram; t = ifa.o_chuc; u = ifa.o_dv;
      of = ifa.o_of; v = ifa.o_valid; b = ifa.o_busy;
    end else begin
      h = ifb.o_tram; t = ifb.o_chuc; u = ifb.o_dv;
      of = ifb.o_of; v = ifb.o_valid; b = ifb.o_busy;
    end
  endtask

  task automatic cmp_model(input int k);
    logic [6:0] eh, et, eu, ah, at, au;
    logic ao, av, ab, eb;
    get_out(k, ah, at, au, ao, av, ab);
    exp_digits(m_disp[k], eh, et, eu);
    eb = (m_pos[k] != -1);
    n_tests++;
    if ({ah, at, au, ao, av, ab} !== {eh, et, eu, m_of[k], m_valid[k], eb}) begin
      n_fail++;
      $display("FAIL model_cmp dut%0d t=%0t actual seg=%h/%h/%h of=%b valid=%b busy=%b required seg=%h/%h/%h of=%b valid=%b busy=%b",
               k, $time, ah, at, au, ao, av, ab, eh, et, eu, m_of[k], m_valid[k], eb);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (tog_a) ifa.i_num_i = ~ifa.i_num_i;
    if (tog_b) ifb.i_num_i = ~ifb.i_num_i;
    if (rst_n === 1'b1) begin
      cmp_model(0);
      cmp_model(1);
    end
  endtask

  task automatic wait_valid(input int k, input int max_cyc, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      seen = (k == 0) ? ifa.o_valid : ifb.o_valid;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_pos(input int target, input int max_cyc, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      seen = (m_pos[0] == target);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic chk_disp(input int k, input string name, input logic [6:0] h,
                          input logic [6:0] t, input logic [6:0] u, input logic of);
    logic [6:0] ah, at, au;
    logic ao, av, ab;
    get_out(k, ah, at, au, ao, av, ab);
    chk({name, "_tram"}, 32'(ah), 32'(h));
    chk({name, "_chuc"}, 32'(at), 32'(t));
    chk({name, "_dv"},   32'(au), 32'(u));
    chk({name, "_of"},   32'(ao), 32'(of));
  endtask

  task automatic chk_reset(input int k, input string name);
    logic [6:0] ah, at, au;
    logic ao, av, ab;
    chk_disp(k, name, LZ, LZ, S0, 1'b0);
    get_out(k, ah, at, au, ao, av, ab);
    chk({name, "_valid"}, 32'(av), 32'd0);
    chk({name, "_busy"},  32'(ab), 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    tog_a = 1'b0; tog_b = 1'b0;
    ifa.i_en = 1'b0; ifa.i_num_i = 1'b0;
    ifb.i_en = 1'b0; ifb.i_num_i = 1'b0;
    repeat (3) tick();
    chk_reset(0, "rst_a");
    chk_reset(1, "rst_b");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy_a", 32'(ifa.o_busy), 32'd0);

    // Long gate: 1250 edges saturate at 999 with overflow
    ifb.i_en = 1'b1; tog_b = 1'b1;
    wait_valid(1, GB + HC + 20, "valid_b_ovf");
    chk_disp(1, "ovf_b", S9, S9, S9, 1'b1);
    // Next gate with no edges clears result and overflow
    tog_b = 1'b0; ifb.i_num_i = 1'b0;
    wait_valid(1, GB + HC + 20, "valid_b_zero");
    chk_disp(1, "zero_b", LZ, LZ, S0, 1'b0);
    ifb.i_en = 1'b0;

    // Pin held high across the whole gate: no edges
    ifa.i_num_i = 1'b1;
    repeat (5) tick();
    ifa.i_en = 1'b1;
    wait_valid(0, GA + HC + 20, "valid_a_high");
    chk_disp(0, "high_a", LZ, LZ, S0, 1'b0);

    // Toggle every cycle: 50 edges in a 100-cycle gate
    tog_a = 1'b1;
    wait_valid(0, GA + HC + 20, "valid_a_50");
    chk_disp(0, "cnt50_a", LZ, S5, S0, 1'b0);
    tick();
    chk("valid_a_one_cycle", 32'(ifa.o_valid), 32'd0);

    // Abort at gate cycle 40: idle next cycle, display retained
    wait_pos(40, 300, "reach_gate40");
    ifa.i_en = 1'b0;
    tick();
    chk("abort_busy", 32'(ifa.o_busy), 32'd0);
    chk("abort_valid", 32'(ifa.o_valid), 32'd0);
    chk_disp(0, "abort_keep", LZ, S5, S0, 1'b0);
    repeat (30) tick();

    // Asynchronous reset mid-gate
    ifa.i_en = 1'b1;
    wait_pos(30, 300, "reach_gate30");
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0, "async_rst_a");
    chk_reset(1, "async_rst_b");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_busy", 32'(ifa.o_busy), 32'd1);
    wait_valid(0, GA + HC + 20, "valid_a_restart");
    chk_disp(0, "restart_a", LZ, S5, S0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
